// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: state codes, opcodes
// and the datapath mux select values driven by the controller.
package ctrl_pkg;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_FETCH  = 4'd1;
  localparam logic [3:0] ST_DECODE = 4'd2;
  localparam logic [3:0] ST_EXEC_R = 4'd3;
  localparam logic [3:0] ST_WB_R   = 4'd4;
  localparam logic [3:0] ST_ADDR   = 4'd5;
  localparam logic [3:0] ST_MEM_RD = 4'd6;
  localparam logic [3:0] ST_WB_MEM = 4'd7;
  localparam logic [3:0] ST_MEM_WR = 4'd8;
  localparam logic [3:0] ST_BRANCH = 4'd9;
  localparam logic [3:0] ST_JUMP   = 4'd10;
  localparam logic [3:0] ST_JAL    = 4'd11;
  localparam logic [3:0] ST_JR     = 4'd12;
  localparam logic [3:0] ST_EXEC_I = 4'd13;
  localparam logic [3:0] ST_WB_I   = 4'd14;
  localparam logic [3:0] ST_FAULT  = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] RDST_RT  = 2'b00;
  localparam logic [1:0] RDST_RD  = 2'b01;
  localparam logic [1:0] RDST_R31 = 2'b10;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  function automatic logic [3:0] decode_state(input logic [5:0] opcode,
                                              input logic [5:0] funct);
    logic [3:0] nxt;
    case (opcode)
      OP_RTYPE:      nxt = (funct == FUNCT_JR) ? ST_JR : ST_EXEC_R;
      OP_LW, OP_SW:  nxt = ST_ADDR;
      OP_BEQ, OP_BNE: nxt = ST_BRANCH;
      OP_J:          nxt = ST_JUMP;
      OP_JAL:        nxt = ST_JAL;
      OP_ADDI:       nxt = ST_EXEC_I;
      default:       nxt = ST_FAULT;
    endcase
    return nxt;
  endfunction

  function automatic logic is_wait_state(input logic [3:0] s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-ready wait counter: counts stalled cycles in a wait state and flags
// a timeout on the cycle that would reach MAX_WAIT (0 disables the timeout).
module mc_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic mem_ready,
  input  logic clear,
  output logic timeout
);

  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = (MAX_WAIT > 0) ? CW'(MAX_WAIT - 1) : '0;
  localparam logic [CW-1:0] SAT = '1;

  logic [CW-1:0] count;
  logic          stalled;

  assign stalled = waiting && !mem_ready;

  // Saturates so an unbounded wait (MAX_WAIT=0) never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (stalled && (count != SAT)) begin
      count <= count + 1'b1;
    end
  end

  assign timeout = (MAX_WAIT != 0) && stalled && (count == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for a multi-cycle MIPS datapath: sequences fetch/decode/execute,
// drives every mux select and strobe, and traps into a sticky FAULT state.
//
// state  | meaning
// IDLE   | post-reset, all strobes off
// FETCH  | read instruction, PC+1 via ALU, wait for mem_ready
// DECODE | branch target into ALUOut, dispatch on opcode
// EXEC_R | R-type ALU operation
// WB_R   | write ALUOut to rd
// ADDR   | lw/sw effective address
// MEM_RD | data read, wait for mem_ready
// WB_MEM | write MDR to rt
// MEM_WR | data write, wait for mem_ready
// BRANCH | beq/bne compare and conditional PC load
// JUMP   | jump
// JAL    | jump and link r31
// JR     | jump to register
// EXEC_I | addi ALU operation
// WB_I   | write ALUOut to rt
// FAULT  | illegal opcode or memory timeout; exits on reset only
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic [1:0] pc_source,
  output logic       iord,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] mem_to_reg,
  output logic [1:0] reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       fault
);

  logic [3:0] cur_state;
  logic [3:0] next_state;
  logic       timeout;

  mc_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .waiting   (is_wait_state(cur_state)),
    .mem_ready (mem_ready),
    .clear     (next_state != cur_state),
    .timeout   (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= ST_IDLE;
    else        cur_state <= next_state;
  end

  // mem_ready takes priority over a simultaneous timeout.
  always_comb begin
    next_state = cur_state;
    case (cur_state)
      ST_IDLE:   next_state = ST_FETCH;
      ST_FETCH:  if (mem_ready) next_state = ST_DECODE;
                 else if (timeout) next_state = ST_FAULT;
      ST_DECODE: next_state = decode_state(opcode, funct);
      ST_EXEC_R: next_state = ST_WB_R;
      ST_ADDR:   next_state = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD: if (mem_ready) next_state = ST_WB_MEM;
                 else if (timeout) next_state = ST_FAULT;
      ST_MEM_WR: if (mem_ready) next_state = ST_FETCH;
                 else if (timeout) next_state = ST_FAULT;
      ST_EXEC_I: next_state = ST_WB_I;
      ST_WB_R, ST_WB_MEM, ST_BRANCH, ST_JUMP,
      ST_JAL, ST_JR, ST_WB_I: next_state = ST_FETCH;
      default:   next_state = ST_FAULT;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = PCSRC_ALU;
    iord          = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = M2R_ALUOUT;
    reg_dst       = RDST_RT;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    instr_done    = 1'b0;
    fault         = 1'b0;
    case (cur_state)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_ONE;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: alu_src_b = SRCB_IMM;
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      ST_WB_R: begin
        reg_dst    = RDST_RD;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      ST_ADDR, ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      ST_WB_MEM: begin
        mem_to_reg = M2R_MDR;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      ST_MEM_WR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        branch_ne     = (opcode == OP_BNE);
        instr_done    = 1'b1;
      end
      ST_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      // Link value is the already-incremented PC.
      ST_JAL: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        reg_dst    = RDST_R31;
        mem_to_reg = M2R_PC;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      ST_JR: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_RS;
        instr_done = 1'b1;
      end
      ST_WB_I: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      ST_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign state = cur_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level model (per-opcode state
// path + per-state output table) checked every cycle, plus literal pins.
module tb_multicycle_ctrl;

  localparam int MW = 4;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       iord;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       fault;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, branch_ne, iord, ir_write, mem_read, mem_write;
  logic       reg_write, alu_src_a, instr_done, fault;
  logic [1:0] pc_source, mem_to_reg, reg_dst, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;

  int n_pass = 0;
  int n_total = 0;

  multicycle_ctrl #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .pc_source(pc_source), .iord(iord), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .state(state), .instr_done(instr_done), .fault(fault)
  );

  always #5 clk = ~clk;

  outs_t dut_out;
  assign dut_out = {pc_write, pc_write_cond, branch_ne, pc_source, iord, ir_write,
                    mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                    alu_src_b, alu_op, instr_done, fault};

  // Remaining states after DECODE, first in the low nibble, 0 = back to FETCH.
  function automatic logic [15:0] plan(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: return (fn == 6'b001000) ? 16'h000C : 16'h0043;
      6'b100011: return 16'h0765;
      6'b101011: return 16'h0085;
      6'b000100, 6'b000101: return 16'h0009;
      6'b000010: return 16'h000A;
      6'b000011: return 16'h000B;
      6'b001000: return 16'h00ED;
      default:   return 16'h000F;
    endcase
  endfunction

  function automatic outs_t exp_outs(input logic [3:0] s, input logic rdy, input logic [5:0] op);
    outs_t o;
    o = '0;
    case (s)
      4'd1:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
      4'd2:  o.alu_src_b = 2'b10;
      4'd3:  begin o.alu_src_a = 1; o.alu_op = 3'b010; end
      4'd4:  begin o.reg_dst = 2'b01; o.reg_write = 1; o.instr_done = 1; end
      4'd5, 4'd13: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      4'd6:  begin o.iord = 1; o.mem_read = 1; end
      4'd7:  begin o.mem_to_reg = 2'b01; o.reg_write = 1; o.instr_done = 1; end
      4'd8:  begin o.iord = 1; o.mem_write = 1; o.instr_done = rdy; end
      4'd9:  begin
        o.alu_src_a = 1; o.alu_op = 3'b001; o.pc_write_cond = 1; o.pc_source = 2'b01;
        o.branch_ne = (op == 6'b000101); o.instr_done = 1;
      end
      4'd10: begin o.pc_write = 1; o.pc_source = 2'b10; o.instr_done = 1; end
      4'd11: begin
        o.pc_write = 1; o.pc_source = 2'b10; o.reg_dst = 2'b10; o.mem_to_reg = 2'b10;
        o.reg_write = 1; o.instr_done = 1;
      end
      4'd12: begin o.pc_write = 1; o.pc_source = 2'b11; o.instr_done = 1; end
      4'd14: begin o.reg_write = 1; o.instr_done = 1; end
      4'd15: o.fault = 1;
      default: ;
    endcase
    return o;
  endfunction

  logic [3:0]  m_state;
  logic [15:0] m_path;
  int          m_wait;
  logic [15:0] plan_now;
  logic        m_waiting;

  assign plan_now  = plan(opcode, funct);
  assign m_waiting = (m_state == 4'd1) || (m_state == 4'd6) || (m_state == 4'd8);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 4'd0;
      m_path  <= '0;
      m_wait  <= 0;
    end else if (m_state == 4'd0) begin
      m_state <= 4'd1;
    end else if (m_state == 4'd15) begin
      m_state <= 4'd15;
    end else if (m_waiting && !mem_ready) begin
      if (MW != 0 && m_wait + 1 == MW) begin
        m_state <= 4'd15;
        m_wait  <= 0;
      end else begin
        m_wait <= m_wait + 1;
      end
    end else begin
      m_wait <= 0;
      if (m_state == 4'd1) begin
        m_state <= 4'd2;
      end else if (m_state == 4'd2) begin
        m_state <= plan_now[3:0];
        m_path  <= plan_now >> 4;
      end else if (m_path == 16'h0) begin
        m_state <= 4'd1;
      end else begin
        m_state <= m_path[3:0];
        m_path  <= m_path >> 4;
      end
    end
  end

  always @(negedge clk) begin
    n_total++;
    if (state !== m_state || dut_out !== exp_outs(m_state, mem_ready, opcode))
      $display("FAIL cycle_compare t=%0t: state %0d outs %h, model state %0d outs %h",
               $time, state, dut_out, m_state, exp_outs(m_state, mem_ready, opcode));
    else
      n_pass++;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  // Called at posedge+1 with FETCH current; ends at posedge+1 of the next FETCH.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int fw_in, input int mw_in, input int exp_cycles,
                           input logic [63:0] exp_seq, input logic [3:0] probe,
                           output outs_t cap);
    int cyc;
    int fw;
    int mwt;
    logic [63:0] seq;
    logic done;
    opcode = op; funct = fn; fw = fw_in; mwt = mw_in;
    cyc = 0; seq = '0; done = 1'b0; cap = '0;
    while (!done && cyc < 40) begin
      if (m_state == 4'd1 && fw > 0) begin
        mem_ready = 1'b0; fw--;
      end else if ((m_state == 4'd6 || m_state == 4'd8) && mwt > 0) begin
        mem_ready = 1'b0; mwt--;
      end else begin
        mem_ready = 1'b1;
      end
      @(negedge clk);
      cyc++;
      seq = {seq[59:0], state};
      if (state == probe) cap = dut_out;
      done = instr_done;
      @(posedge clk); #1;
    end
    check({name, "_cycles"}, 64'(cyc), 64'(exp_cycles));
    check({name, "_states"}, seq, exp_seq);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1);
  end

  initial begin
    outs_t cap;
    int n_fault;
    rst_n = 1'b0; opcode = '0; funct = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", 64'(state), 64'd0);
    check("reset_outs", 64'(dut_out), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("fetch_state", 64'(state), 64'd1);
    check("fetch_mem_read", 64'(mem_read), 64'd1);
    check("fetch_src_b", 64'(alu_src_b), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midfetch_rst_state", 64'(state), 64'd0);
    check("midfetch_rst_outs", 64'(dut_out), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_instr("r_add", 6'h00, 6'h20, 0, 0, 4, 64'h1234, 4'd4, cap);
    check("wb_r_reg_dst", 64'(cap.reg_dst), 64'd1);
    check("wb_r_reg_write", 64'(cap.reg_write), 64'd1);
    run_instr("addi", 6'h08, 6'h00, 0, 0, 4, 64'h12DE, 4'd14, cap);
    run_instr("lw", 6'h23, 6'h00, 0, 0, 5, 64'h12567, 4'd7, cap);
    run_instr("sw", 6'h2B, 6'h00, 0, 0, 4, 64'h1258, 4'd8, cap);
    run_instr("beq", 6'h04, 6'h00, 0, 0, 3, 64'h129, 4'd9, cap);
    check("beq_branch_ne", 64'(cap.branch_ne), 64'd0);
    run_instr("bne", 6'h05, 6'h00, 0, 0, 3, 64'h129, 4'd9, cap);
    check("bne_branch_ne", 64'(cap.branch_ne), 64'd1);
    check("bne_pc_write_cond", 64'(cap.pc_write_cond), 64'd1);
    check("bne_alu_op", 64'(cap.alu_op), 64'd1);
    check("bne_pc_source", 64'(cap.pc_source), 64'd1);
    run_instr("j", 6'h02, 6'h00, 0, 0, 3, 64'h12A, 4'd10, cap);
    run_instr("jal", 6'h03, 6'h00, 0, 0, 3, 64'h12B, 4'd11, cap);
    check("jal_reg_dst", 64'(cap.reg_dst), 64'd2);
    check("jal_mem_to_reg", 64'(cap.mem_to_reg), 64'd2);
    check("jal_pc_source", 64'(cap.pc_source), 64'd2);
    run_instr("jr", 6'h00, 6'h08, 0, 0, 3, 64'h12C, 4'd12, cap);
    check("jr_pc_source", 64'(cap.pc_source), 64'd3);
    check("jr_reg_write", 64'(cap.reg_write), 64'd0);
    run_instr("lw_wait3", 6'h23, 6'h00, 0, 3, 8, 64'h12566667, 4'd7, cap);
    check("wb_mem_to_reg", 64'(cap.mem_to_reg), 64'd1);
    run_instr("sw_wait2", 6'h2B, 6'h00, 0, 2, 6, 64'h125888, 4'd8, cap);
    run_instr("fetch_ready_at_limit", 6'h00, 6'h20, 3, 0, 7, 64'h1111234, 4'd4, cap);

    // Hold mem_ready low in FETCH: four wait cycles, then FAULT.
    mem_ready = 1'b0;
    for (int i = 0; i < MW; i++) begin
      @(negedge clk);
      check("timeout_still_fetch", 64'(state), 64'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("timeout_fault_state", 64'(state), 64'd15);
    check("timeout_fault_flag", 64'(fault), 64'd1);
    @(posedge clk); #1;
    reset_pulse();

    opcode = 6'h3F; funct = 6'h00; mem_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    n_fault = 0;
    repeat (20) begin
      @(negedge clk);
      if (state == 4'd15 && fault && !reg_write && !pc_write && !mem_read && !mem_write)
        n_fault++;
    end
    check("bad_opcode_sticky", 64'(n_fault), 64'd20);
    @(posedge clk); #1;
    reset_pulse();
    run_instr("r_after_fault", 6'h00, 6'h22, 0, 0, 4, 64'h1234, 4'd4, cap);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore/Mealy control FSM that sequences a multi-cycle MIPS datapath: one shared instruction/data memory port, IR, A/B/ALUOut registers, and one ALU reused for PC+1, branch target and execute.
- Drives every mux select and write strobe, decoded from IR opcode/funct.
- Waits on memory ready and reports a sticky fault.
- PC is word-addressed: increment is 1 and branch offsets are not shifted.

Parameters:
MAX_WAIT, 15, memory-ready timeout in cycles; 0 disables the timeout.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; active-low, asynchronous
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
mem_ready  in  1  memory access complete this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  conditional PC load (branch)
branch_ne  out  1  1 = condition is ~zero, 0 = zero
pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump addr, 11 readData1
iord  out  1  memory address: 0 PC, 1 ALUOut
ir_write  out  1  IR load
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
reg_dst  out  2  00 rt, 01 rd, 10 r31
reg_write  out  1  register file write
alu_src_a  out  1  0 PC, 1 A
alu_src_b  out  2  00 B, 01 const 1, 10 sign-extended imm
alu_op  out  3  000 add, 001 sub, 010 use funct
state  out  4  current state code
instr_done  out  1  1-cycle pulse on the final cycle of an instruction
fault  out  1  sticky error flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE(0) and the wait counter is 0.
  - All outputs are 0.
  - IDLE → FETCH unconditionally on the first clock edge after release.
- Outputs are functions of state only, except that ir_write, pc_write and instr_done in wait states are also qualified by mem_ready.
- Any output not listed for a state is 0.
- FETCH(1):
  - iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=000.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_source=00, then → DECODE. Otherwise stay.
- DECODE(2): alu_src_a=0, alu_src_b=10, alu_op=000 (branch target into ALUOut). Next state by opcode:
  - 000000 with funct 001000 → JR.
  - 000000 with any other funct → EXEC_R.
  - 100011 or 101011 → ADDR.
  - 000100 or 000101 → BRANCH.
  - 000010 → JUMP.
  - 000011 → JAL.
  - 001000 → EXEC_I.
  - Any other opcode → FAULT.
- EXEC_R(3): alu_src_a=1, alu_src_b=00, alu_op=010; → WB_R.
- WB_R(4): reg_dst=01, mem_to_reg=00, reg_write=1, instr_done=1; → FETCH.
- ADDR(5): alu_src_a=1, alu_src_b=10, alu_op=000; → MEM_RD for lw, → MEM_WR for sw.
- MEM_RD(6): iord=1, mem_read=1; when mem_ready=1 → WB_MEM.
- WB_MEM(7): reg_dst=00, mem_to_reg=01, reg_write=1, instr_done=1; → FETCH.
- MEM_WR(8): iord=1, mem_write=1, held until mem_ready=1; then instr_done=1 and → FETCH.
- BRANCH(9): alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01, branch_ne=(opcode==000101), instr_done=1; → FETCH.
- JUMP(10): pc_write=1, pc_source=10, instr_done=1; → FETCH.
- JAL(11): pc_write=1, pc_source=10, reg_dst=10, mem_to_reg=10, reg_write=1, instr_done=1; → FETCH. The stored link is PC, which is already PC+1.
- JR(12): pc_write=1, pc_source=11, instr_done=1; → FETCH.
- EXEC_I(13): alu_src_a=1, alu_src_b=10, alu_op=000; → WB_I.
- WB_I(14): reg_dst=00, mem_to_reg=00, reg_write=1, instr_done=1; → FETCH.
- FAULT(15): fault=1, all strobes 0; exits only on reset.
- Wait counter:
  - Increments each cycle in FETCH, MEM_RD or MEM_WR while mem_ready=0.
  - Clears on any state change.
  - With MAX_WAIT≠0, reaching MAX_WAIT while mem_ready=0 → FAULT on the next edge.
  - mem_ready=1 on the same cycle as the limit takes priority (normal transition).
- Cycle counts with zero wait: R 4, addi 4, lw 5, sw 4, beq/bne 3, j/jal/jr 3.
- Reset mid-instruction: returns to IDLE immediately; no strobe is left asserted.

Decomposition:
- Shared package ctrl_pkg holds:
  - state encodings (4-bit);
  - opcode constants OP_RTYPE/LW/SW/BEQ/BNE/J/JAL/ADDI and FUNCT_JR;
  - alu_op, pc_source, mem_to_reg, reg_dst and alu_src_b encodings.
- One sub-module, mc_wait_timer: wait counter plus timeout compare, parameterised by MAX_WAIT.

Test Plan:
- rst_n=0 mid-FETCH → state=0, every output 0; after release, FETCH on the next cycle with mem_read=1, alu_src_b=01.
- opcode 000000, funct 100000, mem_ready=1 throughout → states 1,2,3,4,1; WB_R has reg_dst=01 and reg_write=1; instr_done high on cycle 4 only.
- lw (100011) with mem_ready low 3 cycles in MEM_RD → 3 extra cycles in state 6 with iord=1; then WB_MEM with mem_to_reg=01; total 8 cycles.
- bne (000101) → DECODE then BRANCH with pc_write_cond=1, branch_ne=1, alu_op=001, pc_source=01; beq gives branch_ne=0.
- jal (000011) → JAL with reg_dst=10, mem_to_reg=10, pc_source=10; funct 001000 with opcode 0 → JR with pc_source=11 and reg_write=0.
- Opcode 111111 → FAULT sticky across 20 cycles. Separately, MAX_WAIT=4 with mem_ready held 0 in FETCH → FAULT after 4 cycles; asserting mem_ready on the 4th cycle instead → DECODE.
